// File: rtl/tft_pkg.sv
// Shared panel geometry and default timing constants for the TFT display path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tft_pkg;

    // 480x272 panel, DE-mode timing
    localparam int H_ACTIVE       = 480;
    localparam int H_TOTAL        = 525;
    localparam int V_ACTIVE       = 272;
    localparam int V_TOTAL        = 288;

    // 50 MHz / 6 = 8.33 MHz pixel clock; 5 kHz backlight PWM
    localparam int CLK_DIV_DEF    = 6;
    localparam int READ_LAT_DEF   = 2;
    localparam int PWM_PERIOD_DEF = 10000;

    // frame-buffer coordinate width
    localparam int COORD_W        = 9;

endpackage

// File: rtl/backlight_pwm.sv
// Backlight PWM: led_en high for (bright * PWM_PERIOD) >> 8 clks of every PWM_PERIOD clks.
// Latency: 1 clk from bright/pwm_cnt to led_en.
// Backpressure: none; free-running.
module backlight_pwm
    import tft_pkg::*;
#(
    parameter int PWM_PERIOD = PWM_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       reset_btn,
    input  logic [7:0] bright,
    output logic       led_en
);

    localparam int PW = $clog2(PWM_PERIOD);

    logic [PW-1:0] pwm_cnt;
    logic [21:0]   thr;

    // duty threshold; the 22-bit product covers 255 * 10000
    always_comb begin
        thr = (22'(bright) * 22'(PWM_PERIOD)) >> 8;
    end

    // free-running period counter, unrelated to pixel timing
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PW'(PWM_PERIOD - 1)) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // compare; full brightness is forced on since thr tops out below PWM_PERIOD
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            led_en <= 1'b0;
        end else begin
            led_en <= (bright == 8'hFF) || (22'(pwm_cnt) < thr);
        end
    end

endmodule

// File: rtl/tft_timing_gen.sv
// DE-mode timing, one-pixel-ahead frame-buffer prefetch and panel output registers.
// Latency: a pixel reaches tft_r/g/b one pixel period after its pix_req.
// Backpressure: none; the frame buffer must return data READ_LAT clks after pix_req.
module tft_timing_gen #(
    parameter int CLK_DIV    = tft_pkg::CLK_DIV_DEF,
    parameter int READ_LAT   = tft_pkg::READ_LAT_DEF,
    parameter int PWM_PERIOD = tft_pkg::PWM_PERIOD_DEF,
    parameter int H_ACTIVE   = tft_pkg::H_ACTIVE,
    parameter int H_TOTAL    = tft_pkg::H_TOTAL,
    parameter int V_ACTIVE   = tft_pkg::V_ACTIVE,
    parameter int V_TOTAL    = tft_pkg::V_TOTAL
) (
    input  logic                        clk,
    input  logic                        reset_btn,
    input  logic [7:0]                  bright,
    output logic [tft_pkg::COORD_W-1:0] pix_x,
    output logic [tft_pkg::COORD_W-1:0] pix_y,
    output logic                        pix_req,
    input  logic [23:0]                 pix_rgb,
    output logic [7:0]                  tft_r,
    output logic [7:0]                  tft_g,
    output logic [7:0]                  tft_b,
    output logic                        tft_clk,
    output logic                        tft_de,
    output logic                        tft_en,
    output logic                        tft_display,
    output logic                        led_en,
    output logic                        frame_start,
    output logic                        vblank
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int CW = tft_pkg::COORD_W;

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_nxt;
    logic          tick;
    logic          h_wrap;
    logic          v_wrap;
    logic          fetch_act;
    logic [23:0]   hold_dat;
    logic [23:0]   cap_dat;

    // tick marks the last clk of a pixel period (tft_clk falling edge follows it)
    always_comb begin
        tick      = (div_cnt == DW'(CLK_DIV - 1));
        h_wrap    = (h_cnt == HW'(H_TOTAL - 1));
        v_wrap    = (v_cnt == VW'(V_TOTAL - 1));
        v_nxt     = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cnt + 1'b1;
        end
        fetch_act = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        // when READ_LAT lands on the tick itself, bypass the holding register
        cap_dat   = (div_cnt == DW'(READ_LAT)) ? pix_rgb : hold_dat;
    end

    // 50% duty pixel clock; read strobe in the first clk of an active fetch period
    assign tft_clk = (div_cnt >= DW'(CLK_DIV / 2));
    assign pix_req = tft_en && (div_cnt == '0) && fetch_act;
    assign pix_x   = CW'(h_cnt);
    assign pix_y   = CW'(v_cnt);

    // panel enables come up on the first clk after reset and gate the divider
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            tft_en      <= 1'b0;
            tft_display <= 1'b0;
        end else begin
            tft_en      <= 1'b1;
            tft_display <= 1'b1;
        end
    end

    // divider and h/v counters; v advances on h wrap, both wrap together at frame end
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (tft_en) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
                v_cnt <= v_nxt;
            end
        end
    end

    // capture read data only in its valid cycle; other cycles are ignored
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            hold_dat <= '0;
        end else if (div_cnt == DW'(READ_LAT)) begin
            hold_dat <= pix_rgb;
        end
    end

    // panel outputs change only on tick, showing the pixel fetched this period
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            tft_de                <= 1'b0;
            {tft_r, tft_g, tft_b} <= '0;
        end else if (tick) begin
            tft_de                <= fetch_act;
            {tft_r, tft_g, tft_b} <= fetch_act ? cap_dat : 24'd0;
        end
    end

    // vblank tracks the registered line counter, updated on the same tick
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            vblank <= 1'b0;
        end else if (tick) begin
            vblank <= (v_nxt >= VW'(V_ACTIVE));
        end
    end

    // registered one clk early so frame_start is high exactly on the (0,0) tick
    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= tft_en && (div_cnt == DW'(CLK_DIV - 2)) &&
                           (h_cnt == '0) && (v_cnt == '0);
        end
    end

    backlight_pwm #(
        .PWM_PERIOD (PWM_PERIOD)
    ) u_backlight (
        .clk       (clk),
        .reset_btn (reset_btn),
        .bright    (bright),
        .led_en    (led_en)
    );

endmodule

// File: tb/tb_tft_timing_gen.sv
// Directed bench for tft_timing_gen on a shrunken 8x4 (11x6 total) raster.
// Two instances: READ_LAT=2 and READ_LAT=5, sharing clk, reset and bright.
// Frame buffer model returns {x, y, 8'hA5} exactly READ_LAT clks after pix_req.
module tb_tft_timing_gen;

    localparam int CD    = 6;
    localparam int HA    = 8;
    localparam int HT    = 11;
    localparam int VA    = 4;
    localparam int VT    = 6;
    localparam int PP    = 100;
    localparam int FRAME = HT * VT * CD;  // 396 clks

    logic        clk = 1'b0;
    logic        reset_btn = 1'b1;
    logic [7:0]  bright = 8'd255;

    logic [8:0]  pix_x_a, pix_y_a, pix_x_b, pix_y_b;
    logic        pix_req_a, pix_req_b;
    logic [23:0] pix_rgb_a, pix_rgb_b;
    logic [7:0]  tft_r_a, tft_g_a, tft_b_a, tft_r_b, tft_g_b, tft_b_b;
    logic        tft_clk_a, tft_de_a, tft_en_a, tft_display_a, led_en_a, frame_start_a, vblank_a;
    logic        tft_clk_b, tft_de_b, tft_en_b, tft_display_b, led_en_b, frame_start_b, vblank_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tft_timing_gen #(
        .CLK_DIV(CD), .READ_LAT(2), .PWM_PERIOD(PP),
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) u_dut_a (
        .clk(clk), .reset_btn(reset_btn), .bright(bright),
        .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_req(pix_req_a), .pix_rgb(pix_rgb_a),
        .tft_r(tft_r_a), .tft_g(tft_g_a), .tft_b(tft_b_a), .tft_clk(tft_clk_a),
        .tft_de(tft_de_a), .tft_en(tft_en_a), .tft_display(tft_display_a),
        .led_en(led_en_a), .frame_start(frame_start_a), .vblank(vblank_a)
    );

    tft_timing_gen #(
        .CLK_DIV(CD), .READ_LAT(5), .PWM_PERIOD(PP),
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) u_dut_b (
        .clk(clk), .reset_btn(reset_btn), .bright(bright),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_req(pix_req_b), .pix_rgb(pix_rgb_b),
        .tft_r(tft_r_b), .tft_g(tft_g_b), .tft_b(tft_b_b), .tft_clk(tft_clk_b),
        .tft_de(tft_de_b), .tft_en(tft_en_b), .tft_display(tft_display_b),
        .led_en(led_en_b), .frame_start(frame_start_b), .vblank(vblank_b)
    );

    // frame buffer models: lc counts clks since the request; junk outside the valid cycle
    int         lc_a = 0, lc_b = 0;
    logic [8:0] fx_a = '0, fy_a = '0, fx_b = '0, fy_b = '0;

    always @(posedge clk) begin
        if (pix_req_a) begin
            lc_a <= 1; fx_a <= pix_x_a; fy_a <= pix_y_a;
        end else if (lc_a != 0 && lc_a < 8) lc_a <= lc_a + 1;
        else lc_a <= 0;
        if (pix_req_b) begin
            lc_b <= 1; fx_b <= pix_x_b; fy_b <= pix_y_b;
        end else if (lc_b != 0 && lc_b < 8) lc_b <= lc_b + 1;
        else lc_b <= 0;
    end

    assign pix_rgb_a = (lc_a == 2) ? {fx_a[7:0], fy_a[7:0], 8'hA5} : {16'hDEAD, 8'(lc_a)};
    assign pix_rgb_b = (lc_b == 5) ? {fx_b[7:0], fy_b[7:0], 8'hA5} : {16'hBEEF, 8'(lc_b)};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // returns the number of negedges until frame_start_a is seen, -1 on timeout
    task automatic wait_fs(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (frame_start_a) begin
                n = i;
                break;
            end
        end
    endtask

    // one displayed sample: DE cycles walk the raster in row-major order, CD clks per pixel
    task automatic pix_step(input logic de, input logic [23:0] rgb, inout int idx, inout int err);
        int p;
        logic [23:0] exp;
        if (de) begin
            p   = idx / CD;
            exp = {8'(p % HA), 8'(p / HA), 8'hA5};
            if (rgb !== exp) err++;
            idx++;
        end else if (rgb !== 24'd0) begin
            err++;
        end
    endtask

    int n;
    int clk_err, de_cnt, req_cnt, vb_cnt, fs_cnt;
    int rise0, fall0, rise1;
    int idx_a, idx_b, err_a, err_b;
    logic de_prev;
    logic [23:0] last_a, last_b;
    int led_cnt;
    int bv [6] = '{128, 0, 255, 64, 3, 1};
    int bx [6] = '{50, 0, 100, 25, 1, 0};

    initial begin
        // reset held for 20 clks
        repeat (20) @(negedge clk);
        chk("rst_rgb",   {tft_r_a, tft_g_a, tft_b_a}, 0);
        chk("rst_de",    tft_de_a, 0);
        chk("rst_en",    {tft_en_a, tft_display_a}, 0);
        chk("rst_led",   led_en_a, 0);
        chk("rst_flags", {frame_start_a, vblank_a, pix_req_a, tft_clk_a}, 0);
        chk("rst_pix",   {pix_x_a, pix_y_a}, 0);

        // release: enables rise on the next edge; frame_start 6 edges after release
        reset_btn = 1'b0;
        #1;
        chk("en_before_edge", tft_en_a, 0);
        @(negedge clk);
        chk("en_after_edge", {tft_en_a, tft_display_a}, 2'b11);
        wait_fs(20, n);
        chk("first_fs", n, 5);

        // one full frame from the frame_start cycle (k=0 is the (0,0) tick, div=5)
        clk_err = 0; de_cnt = 0; req_cnt = 0; vb_cnt = 0; fs_cnt = 0;
        rise0 = -1; fall0 = -1; rise1 = -1; de_prev = 1'b0;
        idx_a = 0; idx_b = 0; err_a = 0; err_b = 0; last_a = '0; last_b = '0;
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            if (tft_clk_a !== (((5 + k) % CD) >= CD / 2)) clk_err++;
            if (tft_de_a) begin de_cnt++; last_a = {tft_r_a, tft_g_a, tft_b_a}; end
            if (tft_de_b) last_b = {tft_r_b, tft_g_b, tft_b_b};
            if (pix_req_a) req_cnt++;
            if (vblank_a) vb_cnt++;
            if (frame_start_a) fs_cnt++;
            if (tft_de_a && !de_prev) begin
                if (rise0 < 0) rise0 = k;
                else if (rise1 < 0) rise1 = k;
            end
            if (!tft_de_a && de_prev && fall0 < 0) fall0 = k;
            de_prev = tft_de_a;
            pix_step(tft_de_a, {tft_r_a, tft_g_a, tft_b_a}, idx_a, err_a);
            pix_step(tft_de_b, {tft_r_b, tft_g_b, tft_b_b}, idx_b, err_b);
        end
        chk("tft_clk_pattern", clk_err, 0);
        chk("de_clks_frame", de_cnt, 192);     // 8 px * 4 lines * 6
        chk("req_per_frame", req_cnt, 32);     // 8 * 4
        chk("vblank_clks", vb_cnt, 132);       // 2 lines * 11 * 6
        chk("fs_per_frame", fs_cnt, 1);
        chk("de_first_rise", rise0, 1);
        chk("de_high_len", fall0 - rise0, 48); // 8 ticks
        chk("de_low_len", rise1 - fall0, 18);  // 3 ticks
        chk("pix_err_lat2", err_a, 0);
        chk("pix_err_lat5", err_b, 0);
        chk("last_pix_lat2", last_a, 24'h0703A5);
        chk("last_pix_lat5", last_b, 24'h0703A5);
        @(negedge clk);
        chk("frame_period", {frame_start_a, frame_start_b}, 2'b11);

        // backlight duty over one PWM period
        for (int t = 0; t < 6; t++) begin
            bright = 8'(bv[t]);
            repeat (2) @(negedge clk);
            led_cnt = 0;
            for (int c = 0; c < PP; c++) begin
                @(negedge clk);
                if (led_en_a) led_cnt++;
            end
            chk($sformatf("led_duty_b%0d", bv[t]), led_cnt, bx[t]);
        end

        // mid-frame reset at line 2, pixel 3 fetch
        bright = 8'd255;
        wait_fs(500, n);
        chk("resync_fs", (n > 0), 1);
        repeat (150) @(negedge clk);
        chk("mid_de", tft_de_a, 1);
        chk("mid_pix", {tft_r_a, tft_g_a, tft_b_a}, 24'h0202A5);
        #2;
        reset_btn = 1'b1;
        #1;
        chk("async_rst_a", {tft_r_a, tft_g_a, tft_b_a, tft_de_a, tft_en_a, tft_display_a,
                            tft_clk_a, vblank_a, frame_start_a, pix_req_a, led_en_a}, 0);
        chk("async_rst_b", {tft_r_b, tft_g_b, tft_b_b, tft_de_b, tft_en_b, tft_display_b,
                            tft_clk_b, vblank_b, frame_start_b, pix_req_b, led_en_b}, 0);
        repeat (3) @(negedge clk);
        reset_btn = 1'b0;
        @(negedge clk);
        wait_fs(20, n);
        chk("fs_after_rst", n, 5);
        @(negedge clk);
        chk("row0_de", {tft_de_a, tft_de_b}, 2'b11);
        chk("row0_pix_lat2", {tft_r_a, tft_g_a, tft_b_a}, 24'h0000A5);
        chk("row0_pix_lat5", {tft_r_b, tft_g_b, tft_b_b}, 24'h0000A5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
